mem_stall_ctrl: RTL and testbench

Sequencer for the MEM stage's data-memory access in the pipelined CPU. It converts each load or store leaving EX/MEM into a req/ack transaction with a variable-latency data memory. While the access is outstanding it drives a global stall, so PC, IF/ID, ID/EX, EX/MEM and MEM/WB all hold their values. It returns the load data, held stable, for MEM/WB to capture on the cycle the pipeline resumes.

---
 rtl/mem_stall_ctrl_pkg.sv | 20 ++
 rtl/mem_stall_ctrl_if.sv | 25 ++
 rtl/mem_stall_ctrl_sat_counter.sv | 25 ++
 rtl/mem_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stall_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory stall controller:
// FSM state encoding and default bus widths.
package mem_stall_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller (master) and the
// variable-latency data memory (slave).
interface mem_stall_ctrl_if
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory sequencer: turns a load/store in EX/MEM into a req/ack
// transaction and stalls the pipeline until it completes. Optional watchdog: MEM_TIMEOUT_EN.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    mem_stall_ctrl_if.master    mem_if,
    output logic                stall_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic                err_o
);
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mem_stall_ctrl: TIMEOUT must be nonzero");
    end

    state_e            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_access;
    logic              w_start;
    logic              w_expire;

    assign w_access = MemRead_i | MemWrite_i;
    assign w_start  = (r_state == S_IDLE) && w_access;
    assign stall_o  = w_start || (r_state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] w_wd_cnt;
    logic            r_err;

    // Watchdog counts WAIT cycles; cleared as the access is launched.
    sat_counter #(.W(WD_W)) u_wd_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_clr   (w_start),
        .i_en    (r_state == S_WAIT),
        .o_cnt   (w_wd_cnt)
    );

    assign w_expire = (r_state == S_WAIT) && !mem_if.mem_ack_i &&
                      (w_wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_expire = 1'b0;
    assign err_o    = 1'b0;
`endif

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_clr   (1'b0),
        .i_en    (stall_o),
        .o_cnt   (stall_cnt_o)
    );

    // Request sequencing; a simultaneous read+write request is issued as a write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_we    <= MemWrite_i;
                        r_req   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_if.mem_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= mem_if.mem_rdata_i;
                        end
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_expire) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                // Request still visible here is the retiring instruction; ignore it.
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_if.mem_req_o   = r_req;
    assign mem_if.mem_we_o    = r_we;
    assign mem_if.mem_addr_o  = r_addr;
    assign mem_if.mem_wdata_o = r_wdata;
    assign rdata_o            = r_rdata;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl: loads, stores, back-to-back
// accesses, reset mid-access, spurious acks and (with MEM_TIMEOUT_EN) the watchdog.
module tb_mem_stall_ctrl;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic [15:0] stall_cnt_o;
    logic        err_o;

    int n_vec = 0;
    int n_bad = 0;

    mem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_stall_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .CNT_W   (16),
        .TIMEOUT (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_if      (mif),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .stall_cnt_o (stall_cnt_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle (just after the rising edge) / to mid-cycle for sampling.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_i           = 1'b0;
        MemRead_i       = 1'b0;
        MemWrite_i      = 1'b0;
        addr_i          = 32'h0;
        wdata_i         = 32'h0;
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = 32'h0;

        nxt(); nxt();
        mid();
        chk("rst_req",   32'(mif.mem_req_o),   32'h0);
        chk("rst_we",    32'(mif.mem_we_o),    32'h0);
        chk("rst_addr",  mif.mem_addr_o,       32'h0);
        chk("rst_wdata", mif.mem_wdata_o,      32'h0);
        chk("rst_rdata", rdata_o,              32'h0);
        chk("rst_cnt",   32'(stall_cnt_o),     32'h0);
        chk("rst_err",   32'(err_o),           32'h0);
        chk("rst_stall", 32'(stall_o),         32'h0);

        // Load 0x40, ack in cycle 3
        nxt(); rst_i = 1'b1; MemRead_i = 1'b1; addr_i = 32'h40;
        mid(); chk("ld_c0_stall", 32'(stall_o), 32'h1); chk("ld_c0_req", 32'(mif.mem_req_o), 32'h0);
        nxt();
        mid(); chk("ld_c1_stall", 32'(stall_o), 32'h1); chk("ld_c1_req", 32'(mif.mem_req_o), 32'h1);
        chk("ld_c1_we", 32'(mif.mem_we_o), 32'h0); chk("ld_c1_addr", mif.mem_addr_o, 32'h40);
        nxt();
        mid(); chk("ld_c2_stall", 32'(stall_o), 32'h1); chk("ld_c2_req", 32'(mif.mem_req_o), 32'h1);
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hDEADBEEF;
        mid(); chk("ld_c3_stall", 32'(stall_o), 32'h1); chk("ld_c3_req", 32'(mif.mem_req_o), 32'h1);
        nxt(); mif.mem_ack_i = 1'b0; mif.mem_rdata_i = 32'h0;
        mid(); chk("ld_done_stall", 32'(stall_o), 32'h0); chk("ld_done_req", 32'(mif.mem_req_o), 32'h0);
        chk("ld_done_rdata", rdata_o, 32'hDEADBEEF); chk("ld_done_cnt", 32'(stall_cnt_o), 32'd4);
        nxt(); MemRead_i = 1'b0;
        mid(); chk("ld_idle_stall", 32'(stall_o), 32'h0); chk("ld_idle_cnt", 32'(stall_cnt_o), 32'd4);

        // Store 0x1234 to 0x80, ack in cycle 1
        nxt(); MemWrite_i = 1'b1; addr_i = 32'h80; wdata_i = 32'h1234;
        mid(); chk("st_c0_stall", 32'(stall_o), 32'h1);
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h5A5A5A5A;
        mid(); chk("st_c1_stall", 32'(stall_o), 32'h1); chk("st_c1_req", 32'(mif.mem_req_o), 32'h1);
        chk("st_c1_we", 32'(mif.mem_we_o), 32'h1); chk("st_c1_wdata", mif.mem_wdata_o, 32'h1234);
        chk("st_c1_addr", mif.mem_addr_o, 32'h80);
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("st_done_stall", 32'(stall_o), 32'h0); chk("st_done_rdata", rdata_o, 32'hDEADBEEF);
        chk("st_done_cnt", 32'(stall_cnt_o), 32'd6);
        nxt(); MemWrite_i = 1'b0;
        mid(); chk("st_idle_req", 32'(mif.mem_req_o), 32'h0);

        // Back-to-back loads, each acked one cycle after the request
        nxt(); MemRead_i = 1'b1; addr_i = 32'h100;
        mid(); chk("bb1_c0_stall", 32'(stall_o), 32'h1);
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h11111111;
        mid(); chk("bb1_c1_req", 32'(mif.mem_req_o), 32'h1); chk("bb1_c1_addr", mif.mem_addr_o, 32'h100);
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("bb1_done_stall", 32'(stall_o), 32'h0); chk("bb1_done_req", 32'(mif.mem_req_o), 32'h0);
        chk("bb1_done_rdata", rdata_o, 32'h11111111);
        nxt(); addr_i = 32'h104;
        mid(); chk("bb2_c0_stall", 32'(stall_o), 32'h1); chk("bb2_c0_req", 32'(mif.mem_req_o), 32'h0);
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h22222222;
        mid(); chk("bb2_c1_req", 32'(mif.mem_req_o), 32'h1); chk("bb2_c1_addr", mif.mem_addr_o, 32'h104);
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("bb2_done_rdata", rdata_o, 32'h22222222); chk("bb2_done_cnt", 32'(stall_cnt_o), 32'd10);
        nxt(); MemRead_i = 1'b0;
        mid(); chk("bb_idle_stall", 32'(stall_o), 32'h0);

        // Read+write together is issued as a write; rdata untouched
        nxt(); MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h55;
        nxt();
        mid(); chk("rw_c1_we", 32'(mif.mem_we_o), 32'h1); chk("rw_c1_wdata", mif.mem_wdata_o, 32'h55);
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'h77777777;
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("rw_done_rdata", rdata_o, 32'h22222222); chk("rw_done_cnt", 32'(stall_cnt_o), 32'd13);
        nxt(); MemRead_i = 1'b0; MemWrite_i = 1'b0;

        // Reset in cycle 2 of an outstanding load, ack in cycle 3
        nxt(); MemRead_i = 1'b1; addr_i = 32'h200;
        nxt();
        nxt(); rst_i = 1'b0;
        nxt(); rst_i = 1'b1; MemRead_i = 1'b0; mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hCAFEF00D;
        mid(); chk("mrst_req", 32'(mif.mem_req_o), 32'h0); chk("mrst_addr", mif.mem_addr_o, 32'h0);
        chk("mrst_rdata", rdata_o, 32'h0); chk("mrst_cnt", 32'(stall_cnt_o), 32'h0);
        chk("mrst_stall", 32'(stall_o), 32'h0);
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("mrst_after_rdata", rdata_o, 32'h0); chk("mrst_after_req", 32'(mif.mem_req_o), 32'h0);
        chk("mrst_after_stall", 32'(stall_o), 32'h0);

        // Spurious ack in IDLE with no request
        nxt(); mif.mem_ack_i = 1'b1; mif.mem_rdata_i = 32'hBAD0BAD0;
        mid(); chk("spur_stall", 32'(stall_o), 32'h0);
        nxt(); mif.mem_ack_i = 1'b0;
        mid(); chk("spur_req", 32'(mif.mem_req_o), 32'h0); chk("spur_rdata", rdata_o, 32'h0);
        chk("spur_cnt", 32'(stall_cnt_o), 32'h0); chk("spur_stall2", 32'(stall_o), 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog with TIMEOUT = 8: WAIT cycles 1..8, DONE in cycle 9
        nxt(); MemRead_i = 1'b1; addr_i = 32'h400;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            mid(); chk("to_wait_req", 32'(mif.mem_req_o), 32'h1); chk("to_wait_err", 32'(err_o), 32'h0);
        end
        nxt();
        mid(); chk("to_done_err", 32'(err_o), 32'h1); chk("to_done_req", 32'(mif.mem_req_o), 32'h0);
        chk("to_done_stall", 32'(stall_o), 32'h0); chk("to_done_rdata", rdata_o, 32'h0);
        nxt(); MemRead_i = 1'b0;
        mid(); chk("to_idle_err", 32'(err_o), 32'h1); chk("to_idle_stall", 32'(stall_o), 32'h0);
        nxt(); rst_i = 1'b0;
        nxt(); rst_i = 1'b1;
        mid(); chk("to_rst_err", 32'(err_o), 32'h0);
`else
        chk("err_tied", 32'(err_o), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "simulation time limit reached");
    end
endmodule
